// File: rtl/force_ring_node_gen.sv
// Injection FIFO and ring node for remote forces: ejects slots addressed to other nodes, forwards the rest, injects locally queued forces.
// Latency: one cycle from ring slot in to ring/eject out; remote force in to ring out is at least two cycles.
// Backpressure: o_remote_ready drops when the FIFO is full or in reset; i_rmt_ready low keeps remote slots circulating until they expire.

module force_ring_node_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdat,
  input  logic                   pop,
  output logic [W-1:0]           rdat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdat  = mem[rd_ptr];

  // Entry storage; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module force_ring_node_gen #(
  parameter int FRC_W     = 96,
  parameter int PARID_W   = 8,
  parameter int GCID_W    = 5,
  parameter int X_DIM     = 3,
  parameter int Y_DIM     = 3,
  parameter int Z_DIM     = 3,
  parameter int NODE_ID_W = 3,
  parameter int NUM_DEST  = 7,
  parameter int INJ_DEPTH = 4,
  parameter int HOP_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FRC_W-1:0]            i_remote_force,
  input  logic [3*GCID_W-1:0]         i_remote_gcid,
  input  logic [PARID_W-1:0]          i_remote_parid,
  input  logic                        i_remote_valid,
  output logic                        o_remote_ready,
  input  logic [FRC_W-1:0]            i_src_force,
  input  logic [PARID_W-1:0]          i_src_parid,
  input  logic [3*GCID_W-1:0]         i_src_gcid,
  input  logic [NODE_ID_W-1:0]        i_src_node_id,
  input  logic [HOP_W-1:0]            i_src_hops,
  input  logic                        i_src_valid,
  input  logic [NODE_ID_W-1:0]        i_local_node_id,
  output logic [FRC_W-1:0]            o_dst_force,
  output logic [PARID_W-1:0]          o_dst_parid,
  output logic [3*GCID_W-1:0]         o_dst_gcid,
  output logic [NODE_ID_W-1:0]        o_dst_node_id,
  output logic [HOP_W-1:0]            o_dst_hops,
  output logic                        o_dst_valid,
  output logic [FRC_W-1:0]            o_rmt_force,
  output logic [PARID_W-1:0]          o_rmt_parid,
  output logic [3*GCID_W-1:0]         o_rmt_gcid,
  output logic [NUM_DEST-1:0]         o_rmt_ticket,
  output logic                        o_rmt_valid,
  input  logic                        i_rmt_ready,
  output logic                        o_drop,
  output logic [15:0]                 o_drop_cnt,
  output logic [$clog2(INJ_DEPTH):0]  o_inj_level
);
  localparam int GC_W   = 3 * GCID_W;
  localparam int FIFO_W = FRC_W + PARID_W + GC_W;
  localparam logic [HOP_W-1:0] MAX_HOPS = '1;

  function automatic logic [GCID_W-1:0] axis_dim(input int a);
    case (a)
      0:       return GCID_W'(X_DIM);
      1:       return GCID_W'(Y_DIM);
      default: return GCID_W'(Z_DIM);
    endcase
  endfunction

  logic              fifo_push, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_rdat;
  logic [FRC_W-1:0]  head_force;
  logic [PARID_W-1:0] head_parid;
  logic [GC_W-1:0]   head_gcid;

  logic src_remote, do_eject, do_fwd, do_expire, slot_free, do_inject;
  logic [NODE_ID_W-1:0] diff;
  logic [NUM_DEST-1:0]  ticket;
  logic [GC_W-1:0]      ej_gcid;
  logic [GC_W-1:0]      inj_gcid;
  logic [NODE_ID_W-1:0] inj_node;

  // Ready is held low in reset so nothing is accepted into a clearing FIFO.
  assign o_remote_ready = !rst && !fifo_full;
  // Particle ID 0 marks an empty force: handshaken but never stored.
  assign fifo_push = i_remote_valid && o_remote_ready && (i_remote_parid != '0);

  force_ring_node_fifo #(.W(FIFO_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdat  ({i_remote_force, i_remote_parid, i_remote_gcid}),
    .pop   (do_inject),
    .rdat  (fifo_rdat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_inj_level)
  );

  assign head_force = fifo_rdat[FIFO_W-1 -: FRC_W];
  assign head_parid = fifo_rdat[GC_W +: PARID_W];
  assign head_gcid  = fifo_rdat[GC_W-1:0];

  // Slot disposition: eject, forward, expire, and whether the slot is free for injection.
  assign src_remote = (i_src_node_id != i_local_node_id);
  assign do_eject   = i_src_valid && src_remote && i_rmt_ready;
  assign do_fwd     = i_src_valid && !do_eject;
  assign do_expire  = do_fwd && src_remote && (i_src_hops == MAX_HOPS);
  assign slot_free  = !i_src_valid || do_eject || do_expire;
  assign do_inject  = slot_free && !fifo_empty;
  assign diff       = i_src_node_id ^ i_local_node_id;

  // Destination ticket is the one-hot of (node difference - 1).
  always_comb begin
    ticket = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (diff == NODE_ID_W'(i + 1)) ticket[i] = 1'b1;
    end
  end

  // Per-axis cell ID translation for ejection (node bit x is the MSB, gcid x field the LSBs).
  always_comb begin
    ej_gcid = '0;
    for (int a = 0; a < 3; a++) begin
      logic [GCID_W-1:0] fld;
      fld = i_src_gcid[a*GCID_W +: GCID_W];
      if (i_local_node_id[NODE_ID_W-1-a] && i_src_node_id[NODE_ID_W-1-a])
        fld = fld + axis_dim(a);
      else if (i_local_node_id[NODE_ID_W-1-a] && !i_src_node_id[NODE_ID_W-1-a])
        fld = fld - axis_dim(a);
      ej_gcid[a*GCID_W +: GCID_W] = fld;
    end
  end

  // Injected slot: owner node from which half each cell falls in, cell rebased to the local node.
  always_comb begin
    inj_gcid = '0;
    inj_node = '0;
    for (int a = 0; a < 3; a++) begin
      logic [GCID_W-1:0] fld;
      fld = head_gcid[a*GCID_W +: GCID_W];
      inj_node[NODE_ID_W-1-a] = (fld >= axis_dim(a));
      if (i_local_node_id[NODE_ID_W-1-a]) fld = fld - axis_dim(a);
      inj_gcid[a*GCID_W +: GCID_W] = fld;
    end
  end

  // Registered ring, ejection and drop outputs; idle outputs are driven to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dst_force <= '0; o_dst_parid <= '0; o_dst_gcid <= '0;
      o_dst_node_id <= '0; o_dst_hops <= '0; o_dst_valid <= 1'b0;
      o_rmt_force <= '0; o_rmt_parid <= '0; o_rmt_gcid <= '0;
      o_rmt_ticket <= '0; o_rmt_valid <= 1'b0;
      o_drop <= 1'b0; o_drop_cnt <= '0;
    end else begin
      o_dst_force <= '0; o_dst_parid <= '0; o_dst_gcid <= '0;
      o_dst_node_id <= '0; o_dst_hops <= '0; o_dst_valid <= 1'b0;
      o_rmt_force <= '0; o_rmt_parid <= '0; o_rmt_gcid <= '0;
      o_rmt_ticket <= '0; o_rmt_valid <= 1'b0;
      o_drop <= 1'b0;
      if (do_eject) begin
        o_rmt_force  <= i_src_force;
        o_rmt_parid  <= i_src_parid;
        o_rmt_gcid   <= ej_gcid;
        o_rmt_ticket <= ticket;
        o_rmt_valid  <= 1'b1;
      end
      if (do_fwd && !do_expire) begin
        o_dst_force   <= i_src_force;
        o_dst_parid   <= i_src_parid;
        o_dst_gcid    <= i_src_gcid;
        o_dst_node_id <= i_src_node_id;
        o_dst_hops    <= i_src_hops + 1'b1;
        o_dst_valid   <= 1'b1;
      end else if (do_inject) begin
        o_dst_force   <= head_force;
        o_dst_parid   <= head_parid;
        o_dst_gcid    <= inj_gcid;
        o_dst_node_id <= inj_node;
        o_dst_valid   <= 1'b1;
      end
      if (do_expire) begin
        o_drop <= 1'b1;
        if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_force_ring_node_gen.sv
// Scoreboard bench for force_ring_node_gen: a queue-based model predicts ring, eject and status outputs.
// Latency: expectations are pushed before each clock edge and consumed by the monitor just after it.
// Backpressure: i_rmt_ready and remote pushes are randomized, including pushes into a full FIFO.
module tb_force_ring_node_gen;
  localparam int FRC_W = 96, PARID_W = 8, GCID_W = 5, NODE_ID_W = 3;
  localparam int NUM_DEST = 7, INJ_DEPTH = 4, HOP_W = 4, DIM = 3;
  localparam int LVL_W = $clog2(INJ_DEPTH) + 1;
  localparam int GC_W = 3 * GCID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [FRC_W-1:0] rem_frc, src_frc;
  logic [GC_W-1:0] rem_gcid, src_gcid;
  logic [PARID_W-1:0] rem_parid, src_parid;
  logic rem_vld, src_vld, rmt_rdy;
  logic [NODE_ID_W-1:0] src_node, local_id;
  logic [HOP_W-1:0] src_hops;
  logic o_remote_ready, o_dst_valid, o_rmt_valid, o_drop;
  logic [FRC_W-1:0] o_dst_force, o_rmt_force;
  logic [PARID_W-1:0] o_dst_parid, o_rmt_parid;
  logic [GC_W-1:0] o_dst_gcid, o_rmt_gcid;
  logic [NODE_ID_W-1:0] o_dst_node_id;
  logic [HOP_W-1:0] o_dst_hops;
  logic [NUM_DEST-1:0] o_rmt_ticket;
  logic [15:0] o_drop_cnt;
  logic [LVL_W-1:0] o_inj_level;

  always #5 clk = ~clk;

  force_ring_node_gen dut (
    .clk(clk), .rst(rst),
    .i_remote_force(rem_frc), .i_remote_gcid(rem_gcid), .i_remote_parid(rem_parid),
    .i_remote_valid(rem_vld), .o_remote_ready(o_remote_ready),
    .i_src_force(src_frc), .i_src_parid(src_parid), .i_src_gcid(src_gcid),
    .i_src_node_id(src_node), .i_src_hops(src_hops), .i_src_valid(src_vld),
    .i_local_node_id(local_id),
    .o_dst_force(o_dst_force), .o_dst_parid(o_dst_parid), .o_dst_gcid(o_dst_gcid),
    .o_dst_node_id(o_dst_node_id), .o_dst_hops(o_dst_hops), .o_dst_valid(o_dst_valid),
    .o_rmt_force(o_rmt_force), .o_rmt_parid(o_rmt_parid), .o_rmt_gcid(o_rmt_gcid),
    .o_rmt_ticket(o_rmt_ticket), .o_rmt_valid(o_rmt_valid), .i_rmt_ready(rmt_rdy),
    .o_drop(o_drop), .o_drop_cnt(o_drop_cnt), .o_inj_level(o_inj_level)
  );

  typedef struct { logic [FRC_W-1:0] frc; logic [PARID_W-1:0] parid; logic [GC_W-1:0] gcid; } entry_t;
  typedef struct { entry_t e; logic [NODE_ID_W-1:0] node; logic [HOP_W-1:0] hops; } dst_t;
  typedef struct { entry_t e; logic [NUM_DEST-1:0] ticket; } rmt_t;
  typedef struct { bit dst_vld; bit rmt_vld; bit drop; bit rdy; int level; int cnt; } st_t;

  entry_t m_fifo[$];
  int     m_cnt;
  dst_t   dst_q[$];
  rmt_t   rmt_q[$];
  st_t    st_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int fld(input logic [GC_W-1:0] g, input int a);
    return int'(g[a*GCID_W +: GCID_W]);
  endfunction

  // Node ID is {x,y,z}: axis 0 (x) is the most significant bit.
  function automatic int nbit(input logic [NODE_ID_W-1:0] n, input int a);
    return int'(n[NODE_ID_W-1-a]);
  endfunction

  function automatic logic [GC_W-1:0] eject_gcid(input logic [GC_W-1:0] g,
                                                 input logic [NODE_ID_W-1:0] loc,
                                                 input logic [NODE_ID_W-1:0] src);
    logic [GC_W-1:0] r;
    r = '0;
    for (int a = 0; a < 3; a++) begin
      int v;
      v = fld(g, a);
      if (nbit(loc, a) == 1 && nbit(src, a) == 1) v = v + DIM;
      else if (nbit(loc, a) > nbit(src, a)) v = v - DIM;
      r[a*GCID_W +: GCID_W] = GCID_W'((v + 32) % 32);
    end
    return r;
  endfunction

  function automatic dst_t inject(input entry_t e, input logic [NODE_ID_W-1:0] loc);
    dst_t d;
    d.e = e;
    d.hops = '0;
    d.node = '0;
    for (int a = 0; a < 3; a++) begin
      int v;
      v = fld(e.gcid, a);
      if (v >= DIM) d.node[NODE_ID_W-1-a] = 1'b1;
      if (nbit(loc, a) == 1) v = v - DIM;
      d.e.gcid[a*GCID_W +: GCID_W] = GCID_W'((v + 32) % 32);
    end
    return d;
  endfunction

  // Reference model for one clock edge, evaluated on the inputs currently driven.
  task automatic model_step();
    st_t st;
    dst_t d;
    rmt_t r;
    entry_t e;
    bit remote, freed, rdy_now;
    st = '{default: 0};
    if (rst) begin
      m_fifo.delete();
      m_cnt = 0;
      st_q.push_back(st);
      return;
    end
    rdy_now = (m_fifo.size() < INJ_DEPTH);
    remote  = (src_node != local_id);
    freed   = 1'b1;
    if (src_vld) begin
      if (remote && rmt_rdy) begin
        r.e.frc = src_frc; r.e.parid = src_parid;
        r.e.gcid = eject_gcid(src_gcid, local_id, src_node);
        r.ticket = NUM_DEST'(1) << (int'(src_node ^ local_id) - 1);
        rmt_q.push_back(r);
        st.rmt_vld = 1'b1;
      end else if (remote && int'(src_hops) == (1 << HOP_W) - 1) begin
        st.drop = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        freed = 1'b0;
        d.e.frc = src_frc; d.e.parid = src_parid; d.e.gcid = src_gcid;
        d.node = src_node;
        d.hops = HOP_W'(int'(src_hops) + 1);
        dst_q.push_back(d);
        st.dst_vld = 1'b1;
      end
    end
    if (freed && m_fifo.size() > 0) begin
      dst_q.push_back(inject(m_fifo.pop_front(), local_id));
      st.dst_vld = 1'b1;
    end
    if (rem_vld && rdy_now && rem_parid != '0) begin
      e.frc = rem_frc; e.parid = rem_parid; e.gcid = rem_gcid;
      m_fifo.push_back(e);
    end
    st.level = m_fifo.size();
    st.rdy   = (m_fifo.size() < INJ_DEPTH);
    st.cnt   = m_cnt;
    st_q.push_back(st);
  endtask

  // Monitor: after every edge, check status and pop the scoreboard for each presented output.
  initial begin
    st_t st;
    dst_t d;
    rmt_t r;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        st = st_q.pop_front();
        chk("dst_valid", o_dst_valid, st.dst_vld);
        chk("rmt_valid", o_rmt_valid, st.rmt_vld);
        chk("drop", o_drop, st.drop);
        chk("drop_cnt", o_drop_cnt, st.cnt);
        chk("inj_level", o_inj_level, st.level);
        chk("remote_ready", o_remote_ready, st.rdy);
        if (!o_dst_valid)
          chk("dst_idle_zero", |{o_dst_force, o_dst_parid, o_dst_gcid, o_dst_node_id, o_dst_hops}, 1'b0);
        if (!o_rmt_valid)
          chk("rmt_idle_zero", |{o_rmt_force, o_rmt_parid, o_rmt_gcid, o_rmt_ticket}, 1'b0);
        if (o_dst_valid) begin
          if (dst_q.size() == 0) chk("dst_unexpected", 1'b1, 1'b0);
          else begin
            d = dst_q.pop_front();
            chk("dst_force", o_dst_force, d.e.frc);
            chk("dst_parid", o_dst_parid, d.e.parid);
            chk("dst_gcid", o_dst_gcid, d.e.gcid);
            chk("dst_node", o_dst_node_id, d.node);
            chk("dst_hops", o_dst_hops, d.hops);
          end
        end else if (st.dst_vld && dst_q.size() > 0) void'(dst_q.pop_front());
        if (o_rmt_valid) begin
          if (rmt_q.size() == 0) chk("rmt_unexpected", 1'b1, 1'b0);
          else begin
            r = rmt_q.pop_front();
            chk("rmt_force", o_rmt_force, r.e.frc);
            chk("rmt_parid", o_rmt_parid, r.e.parid);
            chk("rmt_gcid", o_rmt_gcid, r.e.gcid);
            chk("rmt_ticket", o_rmt_ticket, r.ticket);
          end
        end else if (st.rmt_vld && rmt_q.size() > 0) void'(rmt_q.pop_front());
      end
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    src_vld = 0; src_frc = '0; src_parid = '0; src_gcid = '0; src_node = '0; src_hops = '0;
    rem_vld = 0; rem_frc = '0; rem_parid = '0; rem_gcid = '0;
    rmt_rdy = 1;
  endtask

  task automatic do_reset(input logic [NODE_ID_W-1:0] loc);
    idle_inputs();
    rst = 1; local_id = loc;
    tick(); tick();
    rst = 0;
  endtask

  task automatic set_src(input logic [NODE_ID_W-1:0] node, input logic [HOP_W-1:0] hops,
                         input logic [GC_W-1:0] g);
    src_vld = 1; src_node = node; src_hops = hops; src_gcid = g;
    src_frc = {$urandom, $urandom, $urandom};
    src_parid = PARID_W'($urandom_range(1, 255));
  endtask

  initial begin
    idle_inputs();
    local_id = '0;
    rst = 1;
    @(negedge clk);
    tick(); tick();
    chk("reset_dst_valid", o_dst_valid, 1'b0);
    chk("reset_level", o_inj_level, 0);
    chk("reset_ready", o_remote_ready, 1'b0);
    chk("reset_drop_cnt", o_drop_cnt, 0);
    rst = 0;

    // Eject from node 101 to local 000.
    set_src(3'b101, 4'd0, {5'd1, 5'd2, 5'd0});
    rmt_rdy = 1;
    tick();
    chk("ej_valid", o_rmt_valid, 1'b1);
    chk("ej_ticket", o_rmt_ticket, 7'b0010000);
    chk("ej_gcid", o_rmt_gcid, {5'd1, 5'd2, 5'd0});
    chk("ej_dst_valid", o_dst_valid, 1'b0);

    // Forward under backpressure, then eject with x wrapping negative.
    do_reset(3'b100);
    set_src(3'b000, 4'd0, {5'd0, 5'd0, 5'd2});
    rmt_rdy = 0;
    tick();
    chk("fwd_valid", o_dst_valid, 1'b1);
    chk("fwd_hops", o_dst_hops, 4'd1);
    set_src(3'b000, 4'd1, {5'd0, 5'd0, 5'd2});
    rmt_rdy = 1;
    tick();
    chk("ej2_valid", o_rmt_valid, 1'b1);
    chk("ej2_x", o_rmt_gcid[4:0], 5'd31);

    // Expiry at max hops.
    set_src(3'b000, 4'd15, {5'd3, 5'd3, 5'd3});
    rmt_rdy = 0;
    tick();
    chk("exp_dst_valid", o_dst_valid, 1'b0);
    chk("exp_drop", o_drop, 1'b1);
    chk("exp_cnt", o_drop_cnt, 16'd1);
    idle_inputs();
    tick();
    chk("exp_pulse_end", o_drop, 1'b0);

    // Fill FIFO while ring is busy with local forces, then drain in order.
    for (int i = 0; i < 5; i++) begin
      set_src(3'b100, HOP_W'(i), 15'($urandom));
      rem_vld = 1; rem_parid = PARID_W'(i + 1);
      rem_gcid = {5'd1, 5'd2, 5'd4}; rem_frc = {$urandom, $urandom, $urandom};
      tick();
    end
    chk("full_level", o_inj_level, 4);
    chk("full_ready", o_remote_ready, 1'b0);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_valid", o_dst_valid, 1'b1);
      chk("drain_hops", o_dst_hops, 4'd0);
      chk("drain_order", o_dst_parid, PARID_W'(k + 1));
    end

    // Particle ID 0 is discarded; injection with local 111 rebases cells.
    rem_vld = 1; rem_parid = '0; rem_gcid = {5'd4, 5'd4, 5'd4};
    tick();
    chk("pid0_ready", o_remote_ready, 1'b1);
    rem_vld = 0;
    tick();
    chk("pid0_level", o_inj_level, 0);
    chk("pid0_no_inject", o_dst_valid, 1'b0);
    do_reset(3'b111);
    rem_vld = 1; rem_parid = 8'd9; rem_gcid = {5'd4, 5'd4, 5'd4};
    tick();
    chk("no_bypass", o_dst_valid, 1'b0);
    rem_vld = 0;
    tick();
    chk("inj_valid", o_dst_valid, 1'b1);
    chk("inj_node", o_dst_node_id, 3'b111);
    chk("inj_gcid", o_dst_gcid, {5'd1, 5'd1, 5'd1});

    // Mid-operation reset with a slot that would otherwise expire.
    rem_vld = 1; rem_parid = 8'd5;
    set_src(3'b111, 4'd2, 15'd0);
    tick(); tick();
    set_src(3'b000, 4'd15, 15'd0);
    rmt_rdy = 0; rst = 1;
    tick();
    chk("rst_no_drop", o_drop, 1'b0);
    chk("rst_level", o_inj_level, 0);
    chk("rst_cnt", o_drop_cnt, 0);
    rst = 0;
    idle_inputs();
    tick();

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset(NODE_ID_W'($urandom));
      for (int c = 0; c < 300; c++) begin
        src_vld  = ($urandom_range(0, 3) != 0);
        src_node = ($urandom_range(0, 2) == 0) ? local_id : NODE_ID_W'($urandom);
        src_hops = ($urandom_range(0, 2) == 0) ? 4'd15 : HOP_W'($urandom);
        src_gcid = GC_W'($urandom);
        src_frc  = {$urandom, $urandom, $urandom};
        src_parid = PARID_W'($urandom);
        rmt_rdy  = ($urandom_range(0, 2) != 0);
        rem_vld  = ($urandom_range(0, 1) != 0);
        rem_parid = ($urandom_range(0, 5) == 0) ? '0 : PARID_W'($urandom);
        rem_gcid = GC_W'($urandom);
        rem_frc  = {$urandom, $urandom, $urandom};
        rst      = ($urandom_range(0, 120) == 0);
        tick();
      end
      rst = 0;
    end
    idle_inputs();
    tick(); tick();
    chk("dst_q_drained", dst_q.size(), 0);
    chk("rmt_q_drained", rmt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/force_ring_node_gen.md
FORCE_RING_NODE_GEN -- requirements
Module: force_ring_node_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FRC_W, 96, force payload width.
- PARID_W, 8, particle ID width.
- GCID_W, 5, per-axis global cell ID width; gcid fields packed {z,y,x}, x in LSBs.
- X_DIM/Y_DIM/Z_DIM, 3/3/3, cells per axis per node.
- NODE_ID_W, 3, node ID {x,y,z}, one bit per axis.
- NUM_DEST, 7, remote destination tickets.
- INJ_DEPTH, 4, injection FIFO depth (power of 2, >=2).
- HOP_W, 4, hop counter width; MAX_HOPS = 2^HOP_W-1.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk in 1 sole clock; rst in 1 synchronous active-high reset.
- i_remote_force/i_remote_gcid/i_remote_parid in FRC_W/3*GCID_W/PARID_W: inbound remote force.
- i_remote_valid in 1; o_remote_ready out 1: inbound valid/ready.
- i_src_force/i_src_parid/i_src_gcid/i_src_node_id/i_src_hops/i_src_valid in: ring slot from previous node.
- i_local_node_id in NODE_ID_W: this node's ID, static after reset.
- o_dst_force/o_dst_parid/o_dst_gcid/o_dst_node_id/o_dst_hops/o_dst_valid out: ring slot to next node.
- o_rmt_force/o_rmt_parid/o_rmt_gcid out; o_rmt_ticket out NUM_DEST one-hot; o_rmt_valid out 1; i_rmt_ready in 1: ejection port.
- o_drop out 1: one-cycle pulse per expired force; o_drop_cnt out 16 saturating count.
- o_inj_level out clog2(INJ_DEPTH)+1: FIFO occupancy.

Function
REQ-003 All ring and ejection outputs SHALL be registered; one-cycle latency ring-in to ring/eject-out.
REQ-004 Eject: i_src_valid, i_src_node_id != local, i_rmt_ready -> next cycle o_rmt_valid=1 with src force, parid, converted gcid, ticket; ring slot freed.
REQ-005 Ticket SHALL be one-hot bit (diff-1), diff = i_src_node_id XOR i_local_node_id, registered in the same cycle as its data.
REQ-006 Eject gcid per axis: local=1 and src=1 -> +DIM; local<=src -> unchanged; else -DIM; modulo 2^GCID_W.
REQ-007 Forward: i_src_valid and (node == local or i_rmt_ready=0) -> slot copied to o_dst_*, hops+1.
REQ-008 Expire: forward case with node != local and i_src_hops == MAX_HOPS -> slot dropped (o_dst_valid=0, freed), o_drop=1 one cycle, o_drop_cnt+1, saturating at 65535.
REQ-009 Inject: slot free (i_src_valid=0, or ejected, or expired) and FIFO non-empty -> pop head to o_dst_* with hops=0; else o_dst_* all zero.
REQ-010 Injected node_id per axis = (gcid field >= DIM); injected gcid per axis = field - DIM if local axis bit = 1, else unchanged.
REQ-011 FIFO: o_remote_ready = not full; push on i_remote_valid & o_remote_ready; parid==0 handshaken but discarded (not stored).
REQ-012 No bypass: pushed entry injectable earliest next cycle (2-cycle remote-in to ring-out). Push and pop same cycle allowed when not full; level unchanged. When full, ready=0 even if a pop occurs.
REQ-013 o_rmt_valid=0 with all o_rmt_* zero whenever no eject occurs.

Reset
REQ-014 While rst=1 at a clk edge, every output register, FIFO pointers, level, drop counter SHALL clear to 0; o_remote_ready=0 during reset, 1 from first cycle after.
REQ-015 Reset mid-operation SHALL discard all FIFO contents and in-flight slots without emitting o_drop.

Verification
REQ-016 Local=3'b000, src valid node=3'b101, gcid {z=1,y=2,x=0}, ready=1 -> next cycle o_rmt_valid=1, ticket=7'b0010000, gcid unchanged, o_dst_valid=0.
REQ-017 Local=3'b100, src node=3'b000, x=2, i_rmt_ready=0 -> forwarded, hops 0->1; then ready=1 -> ejected, x field=2-3 mod 32=31.
REQ-018 Src valid node != local, hops=15 (HOP_W=4), ready=0 -> o_dst_valid=0, o_drop pulse, o_drop_cnt=1.
REQ-019 Push 4 entries, ring busy (local-node forces) -> o_inj_level=4, o_remote_ready=0; ring idles -> 4 consecutive injections hops=0, FIFO order.
REQ-020 Push parid=0 -> ready handshake, o_inj_level stays 0, no injection; push with local=3'b111, gcid {4,4,4} -> injected node_id=3'b111, gcid {1,1,1}.
